// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over a byte stream, loads a
// 256x16 instruction RAM, verifies the data checksum and then starts the CPU.
// The CPU read port returns zero whenever the CPU is not enabled.
module imem_loader #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic [7:0]  i_addr,
    output logic [15:0] i_datain,
    output logic        cpu_enable,
    output logic        cpu_start,
    output logic        busy,
    output logic        load_error,
    output logic [1:0]  err_code,
    output logic [8:0]  words_loaded
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COUNT   = 3'd1;
    localparam logic [2:0] S_DATA_HI = 3'd2;
    localparam logic [2:0] S_DATA_LO = 3'd3;
    localparam logic [2:0] S_CHECK   = 3'd4;
    localparam logic [2:0] S_START   = 3'd5;
    localparam logic [2:0] S_RUN     = 3'd6;
    localparam logic [2:0] S_ERR     = 3'd7;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [15:0]   r_mem [256];
    logic [7:0]    r_addr;
    logic [7:0]    r_hi;
    logic [7:0]    r_sum;
    logic [8:0]    r_remaining;
    logic [8:0]    r_words;
    logic [TW-1:0] r_idle;
    logic          r_cpu_enable;
    logic          r_cpu_start;
    logic          r_busy;
    logic          r_load_error;
    logic [1:0]    r_err_code;
    logic          w_hdr;
    logic          w_busy_now;
    logic          w_timeout;
    logic          w_enter_count;

    assign w_hdr         = rx_valid && (rx_data == 8'hA5);
    assign w_busy_now    = (r_state == S_COUNT) || (r_state == S_DATA_HI) ||
                           (r_state == S_DATA_LO) || (r_state == S_CHECK);
    assign w_timeout     = w_busy_now && !rx_valid && (r_idle == TW'(TIMEOUT - 1));
    assign w_enter_count = (w_next == S_COUNT) && (r_state != S_COUNT);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a stalled frame is aborted regardless of phase
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_hdr) w_next = S_COUNT;
            S_COUNT:   if (rx_valid) w_next = S_DATA_HI;
            S_DATA_HI: if (rx_valid) w_next = S_DATA_LO;
            S_DATA_LO: if (rx_valid) w_next = (r_remaining == 9'd1) ? S_CHECK : S_DATA_HI;
            S_CHECK:   if (rx_valid) w_next = (rx_data == r_sum) ? S_START : S_ERR;
            S_START:   w_next = S_RUN;
            S_RUN:     if (w_hdr) w_next = S_COUNT;
            S_ERR:     if (w_hdr) w_next = S_COUNT;
            default:   w_next = S_IDLE;
        endcase
        if (w_timeout) w_next = S_ERR;
    end

    // Control/datapath registers; status outputs decoded from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr       <= 8'd0;
            r_hi         <= 8'd0;
            r_sum        <= 8'd0;
            r_remaining  <= 9'd0;
            r_words      <= 9'd0;
            r_idle       <= '0;
            r_cpu_enable <= 1'b0;
            r_cpu_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_load_error <= 1'b0;
            r_err_code   <= 2'b00;
        end else begin
            r_cpu_start  <= (w_next == S_START);
            r_cpu_enable <= (w_next == S_START) || (w_next == S_RUN);
            r_busy       <= (w_next == S_COUNT) || (w_next == S_DATA_HI) ||
                            (w_next == S_DATA_LO) || (w_next == S_CHECK);
            r_load_error <= (w_next == S_ERR);

            if (rx_valid || !w_busy_now) r_idle <= '0;
            else                         r_idle <= r_idle + TW'(1);

            if (w_enter_count) begin
                r_addr     <= 8'd0;
                r_sum      <= 8'd0;
                r_words    <= 9'd0;
                r_err_code <= 2'b00;
            end

            if (rx_valid) begin
                case (r_state)
                    S_COUNT: r_remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    S_DATA_HI: begin
                        r_hi  <= rx_data;
                        r_sum <= r_sum + rx_data;
                    end
                    S_DATA_LO: begin
                        r_addr      <= r_addr + 8'd1;
                        r_words     <= r_words + 9'd1;
                        r_remaining <= r_remaining - 9'd1;
                        r_sum       <= r_sum + rx_data;
                    end
                    S_CHECK: if (rx_data != r_sum) r_err_code <= 2'b01;
                    default: ;
                endcase
            end

            if (w_timeout) r_err_code <= 2'b10;
        end
    end

    // Instruction RAM write on acceptance of each low byte (contents not reset)
    always_ff @(posedge clock) begin
        if ((r_state == S_DATA_LO) && rx_valid) r_mem[r_addr] <= {r_hi, rx_data};
    end

    assign i_datain     = r_cpu_enable ? r_mem[i_addr] : 16'h0000;
    assign cpu_enable   = r_cpu_enable;
    assign cpu_start    = r_cpu_start;
    assign busy         = r_busy;
    assign load_error   = r_load_error;
    assign err_code     = r_err_code;
    assign words_loaded = r_words;

endmodule
